// File: rtl/ram_wt.sv
// ram_wt: write side of the cpu15 data-memory map.
//   Decodes a write strobe into eight 16-bit data words (RAM0..RAM7, addresses
//   0x00..0x07) or the output port register IO64_OUT (address IO_OUT_AD).
//   Writes to any other address, the read-only input port included, leave all
//   data untouched and raise a sticky error that records the first faulting address.
// Ports:
//   CLK_WT     clock, rising edge
//   RESET      synchronous reset, active-high
//   RAM_WEN    write enable, one write per cycle
//   RAM_AD_IN  write address
//   RAM_IN     write data
//   ERR_CLR    clears WT_ERR / WT_ERR_AD
//   RAM0..7    registered data words
//   IO64_OUT   registered output port
//   IO64_STB   one-cycle pulse after each IO64_OUT write
//   WT_ERR     sticky write-fault flag
//   WT_ERR_AD  address of the first faulting write since the last clear
module ram_wt #(
  parameter int unsigned           DATA_W    = 16,
  parameter int unsigned           AD_W      = 8,
  parameter logic [AD_W-1:0]       IO_OUT_AD = 8'h40,
  parameter logic [AD_W-1:0]       IO_IN_AD  = 8'h41,
  parameter logic [DATA_W-1:0]     IO_RST    = 16'h0000
) (
  input  logic              CLK_WT,
  input  logic              RESET,
  input  logic              RAM_WEN,
  input  logic [AD_W-1:0]   RAM_AD_IN,
  input  logic [DATA_W-1:0] RAM_IN,
  input  logic              ERR_CLR,
  output logic [DATA_W-1:0] RAM0,
  output logic [DATA_W-1:0] RAM1,
  output logic [DATA_W-1:0] RAM2,
  output logic [DATA_W-1:0] RAM3,
  output logic [DATA_W-1:0] RAM4,
  output logic [DATA_W-1:0] RAM5,
  output logic [DATA_W-1:0] RAM6,
  output logic [DATA_W-1:0] RAM7,
  output logic [DATA_W-1:0] IO64_OUT,
  output logic              IO64_STB,
  output logic              WT_ERR,
  output logic [AD_W-1:0]   WT_ERR_AD
);

  logic [DATA_W-1:0] mem [8];
  logic              hit_ram;
  logic              hit_io;
  logic              hit_ro;
  logic              fault;

  // Full-width compare: only 0x00..0x07 reach the data words, no aliasing.
  always_comb begin
    hit_ram = (RAM_AD_IN[AD_W-1:3] == '0);
    hit_io  = (RAM_AD_IN == IO_OUT_AD);
    hit_ro  = (RAM_AD_IN == IO_IN_AD);
    fault   = RAM_WEN && (hit_ro || !(hit_ram || hit_io));
  end

  always_ff @(posedge CLK_WT) begin
    if (RESET) begin
      for (int unsigned i = 0; i < 8; i++) mem[i] <= '0;
      IO64_OUT  <= IO_RST;
      IO64_STB  <= 1'b0;
      WT_ERR    <= 1'b0;
      WT_ERR_AD <= '0;
    end else begin
      if (RAM_WEN && hit_ram) mem[RAM_AD_IN[2:0]] <= RAM_IN;
      if (RAM_WEN && hit_io)  IO64_OUT <= RAM_IN;
      IO64_STB <= RAM_WEN && hit_io;
      // A fault in the same cycle as ERR_CLR wins and records its own address.
      if (fault && (!WT_ERR || ERR_CLR)) begin
        WT_ERR    <= 1'b1;
        WT_ERR_AD <= RAM_AD_IN;
      end else if (ERR_CLR) begin
        WT_ERR    <= 1'b0;
        WT_ERR_AD <= '0;
      end
    end
  end

  always_comb begin
    RAM0 = mem[0];
    RAM1 = mem[1];
    RAM2 = mem[2];
    RAM3 = mem[3];
    RAM4 = mem[4];
    RAM5 = mem[5];
    RAM6 = mem[6];
    RAM7 = mem[7];
  end

endmodule

// File: tb/tb_ram_wt.sv
module tb_ram_wt;

  logic        clk;
  logic        reset;
  logic        wen;
  logic [7:0]  ad;
  logic [15:0] din;
  logic        err_clr;
  logic [15:0] ram [8];
  logic [15:0] io_out;
  logic        io_stb;
  logic        wt_err;
  logic [7:0]  wt_err_ad;

  int total = 0;
  int bad   = 0;

  localparam logic [15:0] VALS [8] = '{16'h6535, 16'h7628, 16'h7e6e, 16'habcd,
                                       16'h64a6, 16'h0000, 16'h34b1, 16'h808d};

  ram_wt #(
    .DATA_W(16),
    .AD_W(8),
    .IO_OUT_AD(8'h40),
    .IO_IN_AD(8'h41),
    .IO_RST(16'h0000)
  ) dut (
    .CLK_WT(clk),
    .RESET(reset),
    .RAM_WEN(wen),
    .RAM_AD_IN(ad),
    .RAM_IN(din),
    .ERR_CLR(err_clr),
    .RAM0(ram[0]),
    .RAM1(ram[1]),
    .RAM2(ram[2]),
    .RAM3(ram[3]),
    .RAM4(ram[4]),
    .RAM5(ram[5]),
    .RAM6(ram[6]),
    .RAM7(ram[7]),
    .IO64_OUT(io_out),
    .IO64_STB(io_stb),
    .WT_ERR(wt_err),
    .WT_ERR_AD(wt_err_ad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cycle(input logic rst, input logic w, input logic [7:0] a,
                       input logic [15:0] d, input logic clr);
    reset   = rst;
    wen     = w;
    ad      = a;
    din     = d;
    err_clr = clr;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    wen     = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic test_reset;
    cycle(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (ram[i] !== 16'h0000) begin
        bad++;
        $display("FAIL reset_ram%0d got=%h want=0000", i, ram[i]);
      end
    end
    total++;
    if ({io_out, io_stb, wt_err, wt_err_ad} !== {16'h0000, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_misc got=%h/%b/%b/%h want=0000/0/0/00", io_out, io_stb, wt_err, wt_err_ad);
    end
  endtask

  task automatic test_ram_writes;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 8'(i), VALS[i], 1'b0);
      total++;
      if (ram[i] !== VALS[i]) begin
        bad++;
        $display("FAIL ram_write%0d got=%h want=%h", i, ram[i], VALS[i]);
      end
      total++;
      if (wt_err !== 1'b0) begin
        bad++;
        $display("FAIL ram_write_err%0d got=%b want=0", i, wt_err);
      end
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (ram[i] !== VALS[i]) begin
        bad++;
        $display("FAIL ram_hold%0d got=%h want=%h", i, ram[i], VALS[i]);
      end
    end
  endtask

  task automatic test_io_write;
    cycle(1'b0, 1'b1, 8'h40, 16'h324f, 1'b0);
    total++;
    if (io_out !== 16'h324f || io_stb !== 1'b1) begin
      bad++;
      $display("FAIL io_write got=%h/%b want=324f/1", io_out, io_stb);
    end
    cycle(1'b0, 1'b1, 8'h40, 16'h324f, 1'b0);
    total++;
    if (io_out !== 16'h324f || io_stb !== 1'b1) begin
      bad++;
      $display("FAIL io_rewrite got=%h/%b want=324f/1", io_out, io_stb);
    end
    cycle(1'b0, 1'b0, 8'h40, 16'h9999, 1'b0);
    total++;
    if (io_out !== 16'h324f || io_stb !== 1'b0) begin
      bad++;
      $display("FAIL io_idle got=%h/%b want=324f/0", io_out, io_stb);
    end
  endtask

  task automatic test_fault;
    cycle(1'b0, 1'b1, 8'h41, 16'h1111, 1'b0);
    total++;
    if (wt_err !== 1'b1 || wt_err_ad !== 8'h41) begin
      bad++;
      $display("FAIL fault_ro got=%b/%h want=1/41", wt_err, wt_err_ad);
    end
    total++;
    if (io_out !== 16'h324f || io_stb !== 1'b0) begin
      bad++;
      $display("FAIL fault_ro_io got=%h/%b want=324f/0", io_out, io_stb);
    end
    cycle(1'b0, 1'b1, 8'h08, 16'h2222, 1'b0);
    total++;
    if (wt_err !== 1'b1 || wt_err_ad !== 8'h41) begin
      bad++;
      $display("FAIL fault_sticky got=%b/%h want=1/41", wt_err, wt_err_ad);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (ram[i] !== VALS[i]) begin
        bad++;
        $display("FAIL fault_ram%0d got=%h want=%h", i, ram[i], VALS[i]);
      end
    end
  endtask

  task automatic test_err_clr;
    cycle(1'b0, 1'b1, 8'h80, 16'h5555, 1'b1);
    total++;
    if (wt_err !== 1'b1 || wt_err_ad !== 8'h80) begin
      bad++;
      $display("FAIL clr_vs_fault got=%b/%h want=1/80", wt_err, wt_err_ad);
    end
    cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    total++;
    if (wt_err !== 1'b0 || wt_err_ad !== 8'h00) begin
      bad++;
      $display("FAIL clr_alone got=%b/%h want=0/00", wt_err, wt_err_ad);
    end
    // Fresh fault after a clear records its own address.
    cycle(1'b0, 1'b1, 8'hff, 16'h7777, 1'b0);
    total++;
    if (wt_err !== 1'b1 || wt_err_ad !== 8'hff) begin
      bad++;
      $display("FAIL refault got=%b/%h want=1/ff", wt_err, wt_err_ad);
    end
    total++;
    if (ram[7] !== 16'h808d) begin
      bad++;
      $display("FAIL refault_alias got=%h want=808d", ram[7]);
    end
  endtask

  task automatic test_no_wen;
    cycle(1'b0, 1'b0, 8'h03, 16'hffff, 1'b0);
    total++;
    if (ram[3] !== 16'habcd) begin
      bad++;
      $display("FAIL no_wen got=%h want=abcd", ram[3]);
    end
  endtask

  task automatic test_back_to_back;
    cycle(1'b0, 1'b1, 8'h05, 16'h1234, 1'b0);
    cycle(1'b0, 1'b1, 8'h05, 16'hbeef, 1'b0);
    total++;
    if (ram[5] !== 16'hbeef || ram[4] !== 16'h64a6 || ram[6] !== 16'h34b1) begin
      bad++;
      $display("FAIL last_wins got=%h/%h/%h want=beef/64a6/34b1", ram[5], ram[4], ram[6]);
    end
  endtask

  task automatic test_reset_mid;
    cycle(1'b1, 1'b1, 8'h02, 16'hdead, 1'b0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (ram[i] !== 16'h0000) begin
        bad++;
        $display("FAIL reset_mid_ram%0d got=%h want=0000", i, ram[i]);
      end
    end
    total++;
    if ({io_out, io_stb, wt_err, wt_err_ad} !== {16'h0000, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_mid_misc got=%h/%b/%b/%h want=0000/0/0/00", io_out, io_stb, wt_err, wt_err_ad);
    end
  endtask

  initial begin
    reset   = 1'b0;
    wen     = 1'b0;
    ad      = 8'h00;
    din     = 16'h0000;
    err_clr = 1'b0;
    @(negedge clk);
    test_reset;
    test_ram_writes;
    test_io_write;
    test_fault;
    test_err_clr;
    test_no_wen;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
